// File: rtl/tia_playfield_serializer.sv
// tia_playfield_serializer: playfield registers, horizontal counter and 20-bit playfield serialiser
`timescale 1ns/1ps
module tia_playfield_serializer #(
  parameter int PIXELS_PER_BIT = 4,
  parameter int HBLANK_CLOCKS = 68,
  parameter int LINE_CLOCKS = 228,
  parameter bit BUFFERED = 1'b0
) (
  input  logic       clk,
  input  logic       reset_bar,
  input  logic       line_start,
  input  logic       wr_en,
  input  logic [1:0] wr_sel,
  input  logic [7:0] wr_data,
  output logic [7:0] hpos,
  output logic       blank,
  output logic       pf,
  output logic       pf_right,
  output logic       ctrl_score
);
  localparam logic [7:0] HB = 8'(HBLANK_CLOCKS);
  localparam logic [7:0] LAST = 8'(LINE_CLOCKS - 1);
  localparam logic [7:0] HALF = 8'(20 * PIXELS_PER_BIT);
  localparam logic [7:0] PPB = 8'(PIXELS_PER_BIT);
  logic [7:0] hcount, x, xr, rev;
  logic [4:0] idx;
  logic [19:0] act_bits, sh_bits, base_bits, nxt_bits;
  logic [1:0] act_ctrl, sh_ctrl, base_ctrl, nxt_ctrl;
  logic commit, vis, right, pix;
  assign hpos = hcount;
  assign ctrl_score = act_ctrl[1];
  assign commit = line_start || hcount == LAST;
  assign rev = {<<{wr_data}};
  // merge a register write into whichever copy receives writes (shadow when buffered)
  always_comb begin
    base_bits = BUFFERED ? sh_bits : act_bits;
    base_ctrl = BUFFERED ? sh_ctrl : act_ctrl;
    nxt_bits[3:0] = (wr_en && wr_sel == 2'd0) ? wr_data[7:4] : base_bits[3:0];
    nxt_bits[11:4] = (wr_en && wr_sel == 2'd1) ? rev : base_bits[11:4];
    nxt_bits[19:12] = (wr_en && wr_sel == 2'd2) ? wr_data : base_bits[19:12];
    nxt_ctrl = (wr_en && wr_sel == 2'd3) ? wr_data[1:0] : base_ctrl;
  end
  // select the playfield bit for the current colour clock, mirrored in the right half when reflecting
  always_comb begin
    vis = hcount >= HB;
    x = hcount - HB;
    right = vis && x >= HALF;
    xr = right ? x - HALF : x;
    idx = vis ? 5'(xr / PPB) : 5'd0;
    pix = vis && act_bits[(right && act_ctrl[0]) ? 5'd19 - idx : idx];
  end
  // counter, registered pixel outputs and register commit
  always_ff @(posedge clk) begin
    if (!reset_bar) begin
      hcount <= '0;
      blank <= 1'b1;
      pf <= 1'b0;
      pf_right <= 1'b0;
      act_bits <= '0;
      act_ctrl <= '0;
      sh_bits <= '0;
      sh_ctrl <= '0;
    end else begin
      hcount <= commit ? 8'd0 : hcount + 8'd1;
      blank <= !vis;
      pf <= pix;
      pf_right <= right;
      if (BUFFERED) begin
        sh_bits <= nxt_bits;
        sh_ctrl <= nxt_ctrl;
        if (commit) begin
          act_bits <= nxt_bits;
          act_ctrl <= nxt_ctrl;
        end
      end else begin
        act_bits <= nxt_bits;
        act_ctrl <= nxt_ctrl;
      end
    end
  end
endmodule

// File: doc/tia_playfield_serializer.md
Name: tia_playfield_serializer

Overview:
Parametrised successor to the TIA playfield register block. It holds the three playfield data registers (PF0/PF1/PF2) and a control register, runs its own horizontal colour-clock counter, and serialises the 20-bit playfield across the visible line. Over the original it adds selectable mirror/repeat, score-mode half indication, optional double-buffered (line-synchronous) register commit, and a configurable pixel width and line geometry. It sits between the CPU register-write decode and the TIA colour/priority mux, clocked at the colour clock.

Parameters:
PIXELS_PER_BIT, 4, colour clocks per playfield bit; must be >= 1.
HBLANK_CLOCKS, 68, colour clocks of horizontal blank at line start.
LINE_CLOCKS, 228, total colour clocks per line; must equal HBLANK_CLOCKS + 40*PIXELS_PER_BIT.
BUFFERED, 0, 0 = writes take effect immediately; 1 = writes go to shadow registers and commit at line start.

Ports:
clk  in  1  colour clock; all state updates on rising edge.
reset_bar  in  1  synchronous, active-low reset.
line_start  in  1  one-cycle pulse that forces the horizontal counter to 0 on the next edge.
wr_en  in  1  register write strobe.
wr_sel  in  2  0=PF0, 1=PF1, 2=PF2, 3=CTRL.
wr_data  in  8  write data.
hpos  out  8  current horizontal count, 0..LINE_CLOCKS-1.
blank  out  1  registered; 1 during hblank.
pf  out  1  registered playfield pixel.
pf_right  out  1  registered; 1 when the pixel is in the right half (x >= 20*PIXELS_PER_BIT). Used for score colouring.
ctrl_score  out  1  CTRL bit 1, taken from the active copy.

Behaviour:
- Reset (reset_bar=0 at an edge): hcount=0, all active and shadow registers = 0, pf=0, pf_right=0, blank=1. Reset has priority over line_start and wr_en.
- hcount:
  - Increments each edge and wraps from LINE_CLOCKS-1 to 0.
  - line_start=1 forces 0 on the next edge, overriding the increment.
  - hpos = hcount.
- Bit mapping into pf_bits[19:0]:
  - PF0: wr_data[4..7] -> bits 0..3.
  - PF1: wr_data[7..0] -> bits 4..11 (data[7] = bit 4).
  - PF2: wr_data[0..7] -> bits 12..19.
  - CTRL: bit 0 = reflect, bit 1 = score; other bits ignored.
- Pixel computation from hcount at cycle t, output at edge t+1 (latency 1):
  - x = hcount - HBLANK_CLOCKS.
  - Visible when hcount >= HBLANK_CLOCKS; otherwise pf=0, pf_right=0, blank=1.
  - i = (x mod 20*PPB) / PPB.
  - Left half: pf = pf_bits[i].
  - Right half: pf = reflect ? pf_bits[19-i] : pf_bits[i]; pf_right=1.
- BUFFERED=0:
  - A write at edge k updates the active register at edge k.
  - The pf value registered at edge k+1 uses the new data, so a mid-line write changes output from the next pixel.
- BUFFERED=1:
  - Writes update shadow registers only.
  - Commit (active <= shadow) occurs on the edge where hcount becomes 0, whether by wrap or by line_start.
  - A write coincident with a commit edge is included in the commit (the shadow next-value is forwarded into the active copy).
- Multiple writes to the same register in one line: the last write wins.
- wr_sel=3 also follows the BUFFERED rule.

Test Plan:
- Reset, then hold PF0/PF1/PF2=0 for a full line -> pf=0 at every cycle; blank=1 exactly for hcount 0..67.
- Default params, BUFFERED=0, write PF0=0x50 before line -> pf=1 for hcount samples 68-71 and 76-79, 0 for 72-75 and 80-83 (output one cycle after the hcount sample); the same pattern repeats at 148-151 and 156-159 with pf_right=1.
- PF2=0x80 with CTRL=0x00 -> pf=1 for hcount 144-147 and 224-227. With CTRL=0x01 -> pf=1 for hcount 144-151 contiguous.
- BUFFERED=1: write PF1=0xFF at hcount 100 -> no pf change in the current line; the next line shows pf=1 for hcount 84-115 and 164-195.
- BUFFERED=1: a write coincident with the wrap edge (hcount 227->0) -> the value is visible in the starting line. Also, a line_start pulse at hcount 120 -> hcount=0 on the next edge, commit occurs, blank=1.
- Assert reset_bar=0 mid-line with wr_en=1 -> all outputs and registers return to reset values; the write is discarded.
